shift_sequencer: RTL

Multi-cycle shift controller that drives the combinational `shifter` stage and owns the accumulator register. It accepts a shift command with an opcode and a repeat count. It then feeds the current accumulator and opcode to `shifter` once per clock and writes the result back, for `count` iterations. It tracks the last bit shifted or rotated out as a carry flag, and reports completion with a busy/done handshake to the instruction decoder.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shifter.sv | 16 +
 rtl/shift_sequencer.sv | 78 +++++++
 3 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: opcodes, sequencer states and opcode helpers shared by the shift datapath.
package shift_pkg;
    localparam logic [3:0] SH_NOP = 4'd0;
    localparam logic [3:0] SH_LSL = 4'd1;
    localparam logic [3:0] SH_LSR = 4'd2;
    localparam logic [3:0] SH_CIR = 4'd3;
    localparam logic [3:0] SH_CIL = 4'd4;
    localparam logic [3:0] SH_ASR = 4'd5;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic is_valid_shift(input logic [3:0] op);
        return op >= SH_LSL && op <= SH_ASR;
    endfunction

    // Left-moving ops lose the MSB, everything else loses the LSB.
    function automatic logic exit_bit(input logic [3:0] op, input logic [7:0] a);
        return (op == SH_LSL || op == SH_CIL) ? a[7] : a[0];
    endfunction
endpackage

// File: rtl/shifter.sv
// shifter: single-bit combinational shift/rotate stage; unknown opcodes pass the value through.
module shifter
    import shift_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    always_comb begin
        y_o = op_i == SH_LSL ? {a_i[6:0], 1'b0} :
              op_i == SH_LSR ? {1'b0, a_i[7:1]} :
              op_i == SH_CIR ? {a_i[0], a_i[7:1]} :
              op_i == SH_CIL ? {a_i[6:0], a_i[7]} :
              op_i == SH_ASR ? {a_i[7], a_i[7:1]} : a_i;
    end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: iterates an external shifter over the accumulator for a repeat count,
// tracking the last bit shifted out and reporting busy/done.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [7:0]       load_data,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [CNT_W-1:0] count,
    output logic [3:0]       shift_op,
    output logic [7:0]       acc_to_shifter,
    input  logic [7:0]       shifter_result,
    output logic [7:0]       acc,
    output logic             flag_c,
    output logic             busy,
    output logic             done
);
    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       acc_q, acc_d;
    logic             c_q, c_d;
    logic             go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= SH_NOP;
            cnt_q   <= '0;
            acc_q   <= 8'h00;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
        end
    end

    assign go = is_valid_shift(op) && count != '0;

    // Load beats start; degenerate commands complete immediately without touching acc.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        c_d     = c_q;
        if (state_q == SHIFT) begin
            acc_d   = shifter_result;
            cnt_d   = cnt_q - 1'b1;
            c_d     = exit_bit(op_q, acc_q);
            state_d = cnt_q == CNT_W'(1) ? DONE : SHIFT;
        end else if (load) begin
            acc_d   = load_data;
            state_d = IDLE;
        end else if (start) begin
            op_d    = go ? op : op_q;
            cnt_d   = go ? count : cnt_q;
            state_d = go ? SHIFT : DONE;
        end else begin
            state_d = IDLE;
        end
    end

    assign busy           = state_q == SHIFT;
    assign done           = state_q == DONE;
    assign shift_op       = busy ? op_q : SH_NOP;
    assign acc_to_shifter = acc_q;
    assign acc            = acc_q;
    assign flag_c         = c_q;
endmodule
